mux4_rr_arbiter: RTL and testbench
==================================

Name: mux4_rr_arbiter

Overview:
- Round-robin arbiter that shares one 4-to-1 mux datapath between four requesters.
- Grants one requester at a time and drives the mux's 2-bit select from the registered grant.
- Grant hold is bounded by a burst counter, so no requester can starve the others.
- Sits directly in front of the 4-to-1 mux; the sel output connects straight to the mux select.

Parameters:
- MAX_HOLD, 8: maximum consecutive granted cycles while another request is pending. 0 disables preemption.
- CNT_W, 4: hold-counter width. Must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  4  request per requester. A requester holds its bit high for as long as it needs the mux.
- gnt  output 4  one-hot grant, registered. Bit i high means requester i owns the mux.
- sel  output 2  mux select = index of the granted requester. Holds its last value while idle.
- busy output 1  high while any grant is active (equals OR of gnt).

Behaviour:
- Reset (rst high at a clock edge):
  - gnt=0, sel=0, busy=0, hold_cnt=0, state=IDLE.
  - Priority pointer last=3, so requester 0 has first priority.
  - rst overrides all other inputs and aborts any active grant in that cycle.
- States: IDLE, GRANT.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise pick winner w = first set req bit searching (last+1), (last+2), (last+3), last, all mod 4.
  - Next edge: gnt=onehot(w), sel=w, busy=1, hold_cnt=0, state=GRANT.
  - Latency from request to grant is 1 cycle.
- GRANT, owner o; others = req with bit o masked off:
  - Release: req[o]==0. Next edge: gnt=0, busy=0, last=o, state=IDLE; sel keeps o.
  - Preempt: MAX_HOLD!=0, hold_cnt==MAX_HOLD-1, req[o]==1 and others!=0. Next edge: same as release.
  - Otherwise stay in GRANT. hold_cnt increments, saturating at MAX_HOLD-1.
  - With no contention the owner keeps the grant indefinitely; hold_cnt stays saturated.
  - If a competitor appears while hold_cnt is saturated, preemption occurs on the next edge.
- Every grant change passes through exactly one idle cycle (gnt=0). There is never back-to-back overlap or a glitch between owners.
- A preempted owner that still requests goes to lowest priority in the next arbitration.
- Requests arriving in the bubble cycle are arbitrated in that cycle.
- gnt is always one-hot or zero. sel changes only on the edge where a new grant is issued.
- Simultaneous release and new request from the same requester: release wins. The requester may be re-granted after the bubble, at lowest priority.

Decomposition:
- Shared package holds:
  - NUM_REQ=4 and SEL_W=2.
  - State encoding: IDLE=1'b0, GRANT=1'b1.
  - Default MAX_HOLD.
- One natural sub-module: rr_pick4, a combinational rotate-priority encoder.
  - Inputs: req[3:0], last[1:0]. Outputs: found, idx[1:0].
  - Reused by any future 4-way arbiter.

Test Plan:
- Reset check: assert rst 2 cycles with req=4'b1111 → gnt=0, sel=0, busy=0. First grant after rst deasserts goes to req0 (gnt=0001, sel=0) one cycle later.
- Single requester: req=0100 held 20 cycles, then dropped → gnt=0100 and sel=2 from cycle 1 through 20. gnt=0 the cycle after the drop; sel stays 2.
- Round robin: req=1111 constant, MAX_HOLD=8 → grant order 0,1,2,3,0. Each grant lasts 8 cycles, separated by 1-cycle gnt=0 bubbles.
- Preempt timing: req0 alone for 12 cycles, then req3 rises → req0 loses the grant at the next edge (hold saturated). gnt=1000 and sel=3 one cycle later.
- MAX_HOLD=0 build: req=0011 constant for 50 cycles → gnt=0001 throughout; no preemption.
- Mid-grant reset: req=0010 granted 3 cycles, then rst pulse → gnt=0 on the rst edge. After release the pointer is 3, so with req=0011 requester 0 wins.

Source files
------------

// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared definitions for the 4-way round-robin mux arbiter: sizes, FSM
// encoding, default hold limit and a small one-hot helper.
package mux4_rr_arbiter_pkg;

    localparam int NUM_REQ          = 4;
    localparam int SEL_W            = 2;
    localparam int MAX_HOLD_DEFAULT = 8;
    localparam int CNT_W_DEFAULT    = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    // One-hot vector with only bit idx set.
    function automatic logic [NUM_REQ-1:0] onehot4(input logic [SEL_W-1:0] idx);
        logic [NUM_REQ-1:0] v;
        v      = {NUM_REQ{1'b0}};
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/mux4_rr_arbiter_if.sv
// Request/grant bundle between the four requesters and the arbiter.
// The master side drives requests; the slave side (the arbiter) answers
// with the one-hot grant, the mux select and the busy flag.
interface mux4_rr_arbiter_if;
    import mux4_rr_arbiter_pkg::*;

    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] gnt;
    logic [SEL_W-1:0]   sel;
    logic               busy;

    modport master (
        output req,
        input  gnt,
        input  sel,
        input  busy
    );

    modport slave (
        input  req,
        output gnt,
        output sel,
        output busy
    );

endinterface

// File: rtl/mux4_rr_arbiter_rr_pick4.sv
// Combinational rotating-priority encoder for four requesters.
// The search starts one past the previous winner (last+1) and wraps, so the
// previous winner is considered last. Reusable by any 4-way arbiter.
module rr_pick4 (
    input  logic [3:0] req,
    input  logic [1:0] last,
    output logic       found,
    output logic [1:0] idx
);

    logic [1:0] cand_s;

    // Walk the four candidates in rotated order and keep the first requester.
    always_comb begin
        found  = 1'b0;
        idx    = last;
        cand_s = 2'b00;
        for (int k = 1; k <= 4; k++) begin
            cand_s = last + 2'(k);
            if (!found && req[cand_s]) begin
                found = 1'b1;
                idx   = cand_s;
            end else begin
                found = found;
                idx   = idx;
            end
        end
    end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter in front of a shared 4-to-1 mux. One requester owns
// the mux at a time; ownership is bounded by a hold counter so a busy owner
// is preempted once MAX_HOLD cycles pass with a competitor waiting. Every
// ownership change passes through a single idle (gnt=0) cycle.
module mux4_rr_arbiter
    import mux4_rr_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = MAX_HOLD_DEFAULT,
    parameter int CNT_W    = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    mux4_rr_arbiter_if.slave bus
);

    // Counter value at which the owner has used its full burst. With
    // preemption disabled the counter simply parks at zero.
    localparam logic [CNT_W-1:0] HOLD_SAT_C   = (MAX_HOLD == 0) ? {CNT_W{1'b0}}
                                                                : CNT_W'(MAX_HOLD - 1);
    localparam logic [CNT_W-1:0] HOLD_ONE_C   = CNT_W'(32'd1);
    localparam logic             PREEMPT_EN_C = (MAX_HOLD != 0) ? 1'b1 : 1'b0;

    state_e               state_r;
    state_e               state_nxt_s;
    logic [NUM_REQ-1:0]   gnt_r;
    logic [NUM_REQ-1:0]   gnt_nxt_s;
    logic [SEL_W-1:0]     sel_r;
    logic [SEL_W-1:0]     sel_nxt_s;
    logic [SEL_W-1:0]     last_r;
    logic [SEL_W-1:0]     last_nxt_s;
    logic                 busy_r;
    logic                 busy_nxt_s;
    logic [CNT_W-1:0]     hold_cnt_r;
    logic [CNT_W-1:0]     hold_nxt_s;

    logic                 found_s;
    logic [SEL_W-1:0]     win_s;
    logic [NUM_REQ-1:0]   others_s;
    logic                 hold_sat_s;
    logic                 release_s;
    logic                 preempt_s;

    // Next winner, searched from the requester after the previous owner.
    rr_pick4 u_pick (
        .req   (bus.req),
        .last  (last_r),
        .found (found_s),
        .idx   (win_s)
    );

    // While granting, sel_r is the owner index and gnt_r its one-hot mask,
    // so competitors are simply the requests outside the current grant.
    assign others_s   = bus.req & ~gnt_r;
    assign hold_sat_s = (hold_cnt_r == HOLD_SAT_C);
    assign release_s  = ~bus.req[sel_r];
    assign preempt_s  = PREEMPT_EN_C & hold_sat_s & bus.req[sel_r] & (|others_s);

    // Next-state and next-output logic for the IDLE/GRANT machine.
    always_comb begin
        state_nxt_s = state_r;
        gnt_nxt_s   = gnt_r;
        sel_nxt_s   = sel_r;
        last_nxt_s  = last_r;
        busy_nxt_s  = busy_r;
        hold_nxt_s  = hold_cnt_r;
        case (state_r)
            IDLE: begin
                if (found_s) begin
                    state_nxt_s = GRANT;
                    gnt_nxt_s   = onehot4(win_s);
                    sel_nxt_s   = win_s;
                    busy_nxt_s  = 1'b1;
                    hold_nxt_s  = {CNT_W{1'b0}};
                end else begin
                    state_nxt_s = IDLE;
                    gnt_nxt_s   = {NUM_REQ{1'b0}};
                    busy_nxt_s  = 1'b0;
                end
            end
            GRANT: begin
                if (release_s || preempt_s) begin
                    // Give the mux up; sel keeps pointing at the old owner,
                    // which becomes the lowest-priority requester.
                    state_nxt_s = IDLE;
                    gnt_nxt_s   = {NUM_REQ{1'b0}};
                    busy_nxt_s  = 1'b0;
                    last_nxt_s  = sel_r;
                    hold_nxt_s  = {CNT_W{1'b0}};
                end else if (hold_sat_s) begin
                    hold_nxt_s  = hold_cnt_r;
                end else begin
                    hold_nxt_s  = hold_cnt_r + HOLD_ONE_C;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                gnt_nxt_s   = {NUM_REQ{1'b0}};
                busy_nxt_s  = 1'b0;
                hold_nxt_s  = {CNT_W{1'b0}};
            end
        endcase
    end

    // State and output registers; reset leaves requester 0 with first priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            gnt_r      <= {NUM_REQ{1'b0}};
            sel_r      <= {SEL_W{1'b0}};
            last_r     <= 2'd3;
            busy_r     <= 1'b0;
            hold_cnt_r <= {CNT_W{1'b0}};
        end else begin
            state_r    <= state_nxt_s;
            gnt_r      <= gnt_nxt_s;
            sel_r      <= sel_nxt_s;
            last_r     <= last_nxt_s;
            busy_r     <= busy_nxt_s;
            hold_cnt_r <= hold_nxt_s;
        end
    end

    assign bus.gnt  = gnt_r;
    assign bus.sel  = sel_r;
    assign bus.busy = busy_r;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter. Stimulus tasks push the hand-computed
// post-edge response into a scoreboard queue tagged with the cycle it is due;
// a separate monitor pops and compares on the falling edge. A second DUT is
// built with MAX_HOLD=0 to cover the no-preemption configuration.
module tb_mux4_rr_arbiter;

    typedef struct {
        int         at;
        bit         dsel;
        logic [3:0] gnt;
        logic [1:0] sel;
        logic       busy;
        string      tag;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   tests;
    int   failed;
    exp_t sbq[$];

    mux4_rr_arbiter_if ifa ();
    mux4_rr_arbiter_if ifb ();

    mux4_rr_arbiter #(.MAX_HOLD(8), .CNT_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifa)
    );

    mux4_rr_arbiter #(.MAX_HOLD(0), .CNT_W(4)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Drive the main DUT for one cycle and queue its response after the edge.
    task automatic step(input logic r, input logic [3:0] q, input logic [3:0] eg,
                        input logic [1:0] es, input logic eb, input string tag);
        exp_t e;
        rst     = r;
        ifa.req = q;
        e.at    = cyc + 1;
        e.dsel  = 1'b0;
        e.gnt   = eg;
        e.sel   = es;
        e.busy  = eb;
        e.tag   = tag;
        sbq.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Same for the MAX_HOLD=0 DUT.
    task automatic step0(input logic [3:0] q, input logic [3:0] eg,
                         input logic [1:0] es, input logic eb, input string tag);
        exp_t e;
        rst     = 1'b0;
        ifb.req = q;
        e.at    = cyc + 1;
        e.dsel  = 1'b1;
        e.gnt   = eg;
        e.sel   = es;
        e.busy  = eb;
        e.tag   = tag;
        sbq.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare every due scoreboard entry against the DUT outputs.
    initial begin
        exp_t       e;
        logic [3:0] ag;
        logic [1:0] as;
        logic       ab;
        tests  = 0;
        failed = 0;
        forever begin
            @(negedge clk);
            while (sbq.size() > 0 && sbq[0].at <= cyc) begin
                e = sbq.pop_front();
                if (e.dsel == 1'b0) begin
                    ag = ifa.gnt; as = ifa.sel; ab = ifa.busy;
                end else begin
                    ag = ifb.gnt; as = ifb.sel; ab = ifb.busy;
                end
                tests = tests + 1;
                if (e.at != cyc || ag !== e.gnt || as !== e.sel || ab !== e.busy) begin
                    failed = failed + 1;
                    $display("FAIL %s cyc %0d (due %0d): got gnt=%b sel=%0d busy=%b, expected gnt=%b sel=%0d busy=%b",
                             e.tag, cyc, e.at, ag, as, ab, e.gnt, e.sel, e.busy);
                end
            end
        end
    end

    // Directed stimulus.
    initial begin
        logic [3:0] one;
        logic [1:0] k2;
        rst     = 1'b1;
        ifa.req = 4'b0000;
        ifb.req = 4'b0000;
        @(posedge clk);
        #1;

        // Reset with all requests high.
        step(1'b1, 4'b1111, 4'b0000, 2'd0, 1'b0, "reset0");
        step(1'b1, 4'b1111, 4'b0000, 2'd0, 1'b0, "reset1");

        // Round robin with constant contention: 8-cycle grants, 1-cycle bubbles.
        for (int k = 0; k < 4; k++) begin
            one = 4'b0001 << k;
            k2  = 2'(k);
            for (int j = 0; j < 8; j++) begin
                step(1'b0, 4'b1111, one, k2, 1'b1, "rr_grant");
            end
            step(1'b0, 4'b1111, 4'b0000, k2, 1'b0, "rr_bubble");
        end
        step(1'b0, 4'b1111, 4'b0001, 2'd0, 1'b1, "rr_wrap");
        step(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, "rr_release");
        step(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, "rr_idle");

        // Single requester keeps the grant indefinitely.
        for (int j = 0; j < 20; j++) begin
            step(1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1, "single");
        end
        step(1'b0, 4'b0000, 4'b0000, 2'd2, 1'b0, "single_drop");
        step(1'b0, 4'b0000, 4'b0000, 2'd2, 1'b0, "single_idle");

        // Saturated owner is preempted on the edge after a competitor appears.
        for (int j = 0; j < 12; j++) begin
            step(1'b0, 4'b0001, 4'b0001, 2'd0, 1'b1, "p_req0");
        end
        step(1'b0, 4'b1001, 4'b0000, 2'd0, 1'b0, "p_preempt");
        for (int j = 0; j < 8; j++) begin
            step(1'b0, 4'b1001, 4'b1000, 2'd3, 1'b1, "p_req3");
        end
        step(1'b0, 4'b1001, 4'b0000, 2'd3, 1'b0, "p_bubble");
        step(1'b0, 4'b1001, 4'b0001, 2'd0, 1'b1, "p_back0");
        step(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, "p_release");
        step(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, "p_idle");

        // Reset in the middle of a grant aborts it and restores the pointer.
        for (int j = 0; j < 3; j++) begin
            step(1'b0, 4'b0010, 4'b0010, 2'd1, 1'b1, "mr_grant");
        end
        step(1'b1, 4'b0010, 4'b0000, 2'd0, 1'b0, "mr_rst");
        step(1'b0, 4'b0011, 4'b0001, 2'd0, 1'b1, "mr_after");
        step(1'b0, 4'b0011, 4'b0001, 2'd0, 1'b1, "mr_hold");
        step(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, "mr_release");

        // MAX_HOLD=0 build: no preemption under contention.
        for (int j = 0; j < 50; j++) begin
            step0(4'b0011, 4'b0001, 2'd0, 1'b1, "nohold");
        end
        step0(4'b0000, 4'b0000, 2'd0, 1'b0, "nohold_release");

        // Let the monitor drain the scoreboard, bounded.
        for (int j = 0; j < 10 && sbq.size() > 0; j++) begin
            @(posedge clk);
        end
        @(negedge clk);
        #1;
        if (sbq.size() != 0) begin
            tests  = tests + 1;
            failed = failed + 1;
            $display("FAIL drain: %0d entries left, expected 0", sbq.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
